beat_flywheel: RTL
==================

// Module: beat_flywheel
// PURPOSE
//  Consumes beat_track's per-frame beat decision and produces a stable tempo estimate plus a stretched,
//  LED/MCU-visible beat pulse. Measures frame intervals between detected beats and averages them.
//  Once the interval is consistent it locks and "flywheels": inserts predicted beats when detections drop out.
//  Sits directly downstream of beat_track, clocked in the FFT/beat domain.
// PARAMETERS
//  PERIOD_W      8        width of frame counters / period estimate (frames)
//  MIN_PERIOD    10       smallest accepted beat interval (frames); shorter events discarded
//  MAX_PERIOD    120      largest interval; frame counter exceeding this in TRACK/LOCKED -> SEARCH
//  TOL           2        +/- frames for an interval to "match" the period estimate
//  LOCK_COUNT    3        consecutive matched intervals required to assert locked
//  MAX_MISS      4        consecutive predicted (undetected) beats before dropping lock
//  PULSE_CYCLES  1000000  clocks beat_pulse stays high per beat (must be >= 1)
// PORTS
//  clk           in   1         system clock
//  reset         in   1         asynchronous, active-high reset
//  frame_strobe  in   1         1-cycle pulse per FFT frame, asserted the cycle after beat_in updates
//  beat_in       in   1         beat_track beat_out level; sampled only when frame_strobe=1
//  beat_pulse    out  1         stretched beat indication (detected or predicted)
//  beat_src      out  1         source of last pulse: 0=detected, 1=predicted
//  period        out  PERIOD_W  current tempo estimate in frames (0 = none)
//  phase         out  PERIOD_W  frames since last beat (internal frame counter)
//  locked        out  1         1 while in LOCKED state
// BEHAVIOUR
//  - Reset (async, wins over everything): state=SEARCH; all outputs, ctr, match_cnt, miss_cnt, pulse_ctr = 0.
//  - All logic advances only on frame_strobe except pulse_ctr (every clk). event = frame_strobe & beat_in.
//  - ctr_next = ctr+1, saturating at 2^PERIOD_W-1. ctr <= ctr_next each strobe unless stated otherwise.
//  - SEARCH: event -> TRACK, ctr<=0, match_cnt<=0, accepted (pulse). No strobe -> ctr holds.
//  - TRACK, event with interval=ctr_next:
//      interval < MIN_PERIOD -> event discarded entirely (no pulse, ctr<=ctr_next).
//      |interval-period|<=TOL -> match_cnt+1, period<=(period+interval+1)>>1 (PERIOD_W+1-bit sum).
//      else -> match_cnt<=0, period<=interval.
//      accepted events: ctr<=0, pulse. match_cnt reaching LOCK_COUNT -> LOCKED, miss_cnt<=0.
//    TRACK, no event and ctr_next > MAX_PERIOD -> SEARCH, period<=0, match_cnt<=0.
//  - LOCKED, event:
//      interval in [period-TOL, period+TOL] -> period averaged as above, ctr<=0, miss_cnt<=0, pulse, src=0.
//      interval < period-TOL -> stray: ignored (no pulse, counters untouched beyond ctr<=ctr_next).
//    LOCKED, no event and ctr_next == period+TOL -> predicted beat: pulse, src=1, ctr<=TOL (keeps phase),
//      miss_cnt+1; if miss_cnt+1 == MAX_MISS -> SEARCH, period<=0, locked<=0 (pulse still emitted).
//  - Same-strobe conflict: a detected event always wins over prediction.
//  - locked is registered: rises/falls on the clk after the deciding strobe.
//  - beat_pulse: a pulse loads pulse_ctr=PULSE_CYCLES on the clk after the strobe; beat_pulse=(pulse_ctr!=0);
//    pulse_ctr decrements each clk; a new pulse while high reloads (retrigger), no gap.
//  - beat_src and period update on the same clk edge as the pulse load; hold otherwise.
//  - Encoding: states 2-bit SEARCH/TRACK/LOCKED; illegal state -> SEARCH.
// TESTING (PULSE_CYCLES=4, other params default; strobe every 8 clks)
//  1 Reset: assert reset mid-stream -> beat_pulse, locked, period, phase = 0 immediately (no clk edge).
//  2 Beats every 40 frames x5 -> locked=1 after 5th beat, period=40, each beat_pulse high exactly 4 clks.
//  3 Locked at 40, beats stop -> predicted pulses (src=1) 42, 82, 122, 162 frames after last beat;
//    after the 4th, locked=0, period=0, state SEARCH.
//  4 In TRACK, beat 5 frames after previous -> no pulse, phase keeps counting, period unchanged.
//  5 In TRACK, no beat for 121 frames -> SEARCH, period=0; next beat gives pulse, no lock.
//  6 Locked at 40, beat at 41 then 39 -> both matched, period stays 40/41 by rounding rule, miss_cnt=0.

Source files
------------

// File: rtl/beat_flywheel.sv
// Tempo estimator and beat flywheel fed by beat_track's per-frame beat decision.
// Averages detected beat intervals, locks onto a steady tempo and inserts predicted beats on dropouts.
module beat_flywheel #(
    parameter int PERIOD_W     = 8,
    parameter int MIN_PERIOD   = 10,
    parameter int MAX_PERIOD   = 120,
    parameter int TOL          = 2,
    parameter int LOCK_COUNT   = 3,
    parameter int MAX_MISS     = 4,
    parameter int PULSE_CYCLES = 1000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                frame_strobe,
    input  logic                beat_in,
    output logic                beat_pulse,
    output logic                beat_src,
    output logic [PERIOD_W-1:0] period,
    output logic [PERIOD_W-1:0] phase,
    output logic                locked
);

    localparam int XW   = PERIOD_W + 1;
    localparam int MC_W = $clog2(LOCK_COUNT + 1);
    localparam int MS_W = $clog2(MAX_MISS + 1);
    localparam int PC_W = $clog2(PULSE_CYCLES + 1);

    localparam logic [1:0] SEARCH = 2'd0;
    localparam logic [1:0] TRACK  = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    localparam logic [PERIOD_W-1:0] CTR_MAX = '1;
    localparam logic [PERIOD_W-1:0] TOL_P   = PERIOD_W'(TOL);
    localparam logic [XW-1:0]       TOL_X   = XW'(TOL);
    localparam logic [XW-1:0]       MIN_X   = XW'(MIN_PERIOD);
    localparam logic [XW-1:0]       MAX_X   = XW'(MAX_PERIOD);
    localparam logic [MC_W-1:0]     LOCK_C  = MC_W'(LOCK_COUNT);
    localparam logic [MS_W-1:0]     MISS_C  = MS_W'(MAX_MISS);
    localparam logic [PC_W-1:0]     PULSE_C = PC_W'(PULSE_CYCLES);

    logic [1:0]          state_q, state_d;
    logic [PERIOD_W-1:0] ctr_q, ctr_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [MC_W-1:0]     matchCnt_q, matchCnt_d;
    logic [MS_W-1:0]     missCnt_q, missCnt_d;
    logic                src_q, src_d;
    logic                locked_q;
    logic [PC_W-1:0]     pulseCtr_q;

    logic [PERIOD_W-1:0] ctrNext;
    logic [XW-1:0]       interval, periodX, absDiff, avgSum;
    logic [MC_W-1:0]     matchInc;
    logic [MS_W-1:0]     missInc;
    logic                beatEvent, inWindow, pulseLoad;

    always_comb begin
        beatEvent = frame_strobe & beat_in;
        ctrNext   = (ctr_q == CTR_MAX) ? ctr_q : ctr_q + PERIOD_W'(1);
        interval  = {1'b0, ctrNext};
        periodX   = {1'b0, period_q};
        absDiff   = (interval >= periodX) ? interval - periodX : periodX - interval;
        inWindow  = (absDiff <= TOL_X);
        // Rounded mean of old estimate and new interval; the extra bit keeps the sum from wrapping.
        avgSum    = periodX + interval + XW'(1);
        matchInc  = matchCnt_q + MC_W'(1);
        missInc   = missCnt_q + MS_W'(1);
    end

    always_comb begin
        state_d    = state_q;
        ctr_d      = ctr_q;
        period_d   = period_q;
        matchCnt_d = matchCnt_q;
        missCnt_d  = missCnt_q;
        src_d      = src_q;
        pulseLoad  = 1'b0;
        if (frame_strobe) begin
            ctr_d = ctrNext;
            case (state_q)
                SEARCH: begin
                    if (beatEvent) begin
                        state_d    = TRACK;
                        ctr_d      = '0;
                        matchCnt_d = '0;
                        src_d      = 1'b0;
                        pulseLoad  = 1'b1;
                    end
                end
                TRACK: begin
                    if (beatEvent) begin
                        if (interval >= MIN_X) begin
                            ctr_d     = '0;
                            src_d     = 1'b0;
                            pulseLoad = 1'b1;
                            if (inWindow) begin
                                matchCnt_d = matchInc;
                                period_d   = PERIOD_W'(avgSum >> 1);
                                if (matchInc == LOCK_C) begin
                                    state_d   = LOCKED;
                                    missCnt_d = '0;
                                end
                            end else begin
                                matchCnt_d = '0;
                                period_d   = ctrNext;
                            end
                        end
                    end else if (interval > MAX_X) begin
                        state_d    = SEARCH;
                        period_d   = '0;
                        matchCnt_d = '0;
                    end
                end
                LOCKED: begin
                    // A real detection always beats a prediction landing on the same frame.
                    if (beatEvent) begin
                        if (inWindow) begin
                            period_d  = PERIOD_W'(avgSum >> 1);
                            ctr_d     = '0;
                            missCnt_d = '0;
                            src_d     = 1'b0;
                            pulseLoad = 1'b1;
                        end
                    end else if (interval == periodX + TOL_X) begin
                        ctr_d     = TOL_P;
                        missCnt_d = missInc;
                        src_d     = 1'b1;
                        pulseLoad = 1'b1;
                        if (missInc == MISS_C) begin
                            state_d  = SEARCH;
                            period_d = '0;
                        end
                    end
                end
                default: begin
                    state_d    = SEARCH;
                    ctr_d      = '0;
                    period_d   = '0;
                    matchCnt_d = '0;
                    missCnt_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= SEARCH;
            ctr_q      <= '0;
            period_q   <= '0;
            matchCnt_q <= '0;
            missCnt_q  <= '0;
            src_q      <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctr_q      <= ctr_d;
            period_q   <= period_d;
            matchCnt_q <= matchCnt_d;
            missCnt_q  <= missCnt_d;
            src_q      <= src_d;
            locked_q   <= (state_d == LOCKED);
        end
    end

    // Stretches each accepted or predicted beat; a new beat reloads without a gap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pulseCtr_q <= '0;
        end else if (pulseLoad) begin
            pulseCtr_q <= PULSE_C;
        end else if (pulseCtr_q != '0) begin
            pulseCtr_q <= pulseCtr_q - PC_W'(1);
        end
    end

    assign beat_pulse = (pulseCtr_q != '0);
    assign beat_src   = src_q;
    assign period     = period_q;
    assign phase      = ctr_q;
    assign locked     = locked_q;

endmodule
